fb_swap_ctrl: RTL and testbench

FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

---
 rtl/fb_swap_ctrl.sv | 116 +++++++++++
 tb/tb_fb_swap_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// Frame-buffer swap controller: waits for a drawn frame to finish its writes,
// then swaps buffers on the display's vsync falling edge (or immediately before first display).
module fb_swap_ctrl #(
   parameter int unsigned OUTSTANDING_BITS = 4,
   parameter int unsigned FRAME_CNT_BITS   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        gfx_last,
   input  logic                        wr_issue,
   input  logic                        wr_done,
   input  logic                        vsync,
   output logic                        mem_switch,
   output logic                        gfx_start,
   output logic                        disp_enable,
   output logic [OUTSTANDING_BITS-1:0] outstanding,
   output logic [FRAME_CNT_BITS-1:0]   frame_cnt,
   output logic [FRAME_CNT_BITS-1:0]   drop_cnt,
   output logic                        err
);

   localparam int unsigned OB = OUTSTANDING_BITS;
   localparam int unsigned FB = FRAME_CNT_BITS;
   localparam logic [OB-1:0] OUT_MAX = '1;

   typedef enum logic [1:0] {
      DRAW  = 2'd0,
      DRAIN = 2'd1,
      READY = 2'd2,
      SWAP  = 2'd3
   } state_t;

   state_t        state, state_d;
   logic          vsync_q;
   logic          vsync_fall;
   logic          vsync_fall_d;
   logic          mem_switch_d;
   logic          gfx_start_d;
   logic          disp_enable_d;
   logic [OB-1:0] outstanding_d;
   logic [FB-1:0] frame_cnt_d;
   logic [FB-1:0] drop_cnt_d;
   logic          err_d;

   // State and all outputs register here; next values come from the comb block below.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= DRAW;
         vsync_q     <= 1'b0;
         vsync_fall  <= 1'b0;
         mem_switch  <= 1'b0;
         gfx_start   <= 1'b0;
         disp_enable <= 1'b0;
         outstanding <= '0;
         frame_cnt   <= '0;
         drop_cnt    <= '0;
         err         <= 1'b0;
      end else begin
         state       <= state_d;
         vsync_q     <= vsync;
         vsync_fall  <= vsync_fall_d;
         mem_switch  <= mem_switch_d;
         gfx_start   <= gfx_start_d;
         disp_enable <= disp_enable_d;
         outstanding <= outstanding_d;
         frame_cnt   <= frame_cnt_d;
         drop_cnt    <= drop_cnt_d;
         err         <= err_d;
      end
   end

   // Next-state, counters and swap pulses.
   always_comb begin
      state_d       = state;
      vsync_fall_d  = vsync_q & ~vsync;
      disp_enable_d = disp_enable;
      outstanding_d = outstanding;
      frame_cnt_d   = frame_cnt;
      drop_cnt_d    = drop_cnt;
      err_d         = err;

      unique case (state)
         DRAW: begin
            if (gfx_last) state_d = DRAIN;
         end
         DRAIN: begin
            if ((outstanding == '0) && !wr_issue) state_d = READY;
         end
         READY: begin
            if (!disp_enable || vsync_fall) state_d = SWAP;
         end
         SWAP: begin
            state_d       = DRAW;
            disp_enable_d = 1'b1;
            frame_cnt_d   = frame_cnt + FB'(1);
         end
         default: state_d = DRAW;
      endcase

      // A displayed frame repeats when vsync arrives before the next one is ready.
      if (vsync_fall && disp_enable && ((state == DRAW) || (state == DRAIN)))
         drop_cnt_d = drop_cnt + FB'(1);

      if (wr_issue && !wr_done) begin
         if (outstanding == OUT_MAX) err_d = 1'b1;
         else                        outstanding_d = outstanding + OB'(1);
      end else if (wr_done && !wr_issue) begin
         if (outstanding == '0) err_d = 1'b1;
         else                   outstanding_d = outstanding - OB'(1);
      end

      mem_switch_d = (state_d == SWAP);
      gfx_start_d  = (state_d == SWAP);
   end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Self-checking bench for fb_swap_ctrl: swap cycles tracked by a scoreboard queue,
// counters and levels checked directly against bench-computed values.
module tb_fb_swap_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        gfx_last, wr_issue, wr_done, vsync;
   logic        mem_switch, gfx_start, disp_enable, err;
   logic [3:0]  outstanding;
   logic [15:0] frame_cnt, drop_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_q[$];

   fb_swap_ctrl #(.OUTSTANDING_BITS(4), .FRAME_CNT_BITS(16)) dut (
      .clk(clk), .reset(reset), .gfx_last(gfx_last), .wr_issue(wr_issue),
      .wr_done(wr_done), .vsync(vsync), .mem_switch(mem_switch),
      .gfx_start(gfx_start), .disp_enable(disp_enable), .outstanding(outstanding),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Push the cycle in which the swap pulse must appear.
   task automatic expect_swap(input int at);
      exp_q.push_back(at);
   endtask

   task automatic vsync_fall_now();
      vsync = 1'b0;
      expect_swap(cyc + 2);
      tick(1);
      vsync = 1'b1;
   endtask

   task automatic vsync_drop();
      vsync = 1'b0;
      tick(1);
      vsync = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_mem_switch"}, 32'(mem_switch), 32'd0);
      check_eq({tag, "_gfx_start"}, 32'(gfx_start), 32'd0);
      check_eq({tag, "_disp_enable"}, 32'(disp_enable), 32'd0);
      check_eq({tag, "_outstanding"}, 32'(outstanding), 32'd0);
      check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // Scoreboard side: every swap pulse must match the oldest expected cycle.
   always @(negedge clk) begin
      if (!reset && (mem_switch || gfx_start)) begin
         check_eq("gfx_start_eq_mem_switch", 32'(gfx_start), 32'(mem_switch));
         if (exp_q.size() == 0) check_eq("spurious_swap", 32'(cyc), 32'hFFFF_FFFF);
         else                   check_eq("swap_cycle", 32'(cyc), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; gfx_last = 1'b0; wr_issue = 1'b0; wr_done = 1'b0; vsync = 1'b1;
      tick(3);
      check_reset_vals("rst");
      reset = 1'b0;
      tick(1);
      check_reset_vals("post_rst");

      // Startup: writes drain, first frame swaps 3 cycles after gfx_last with no vsync.
      wr_issue = 1'b1; tick(3); wr_issue = 1'b0;
      check_eq("start_out3", 32'(outstanding), 32'd3);
      wr_done = 1'b1; tick(3); wr_done = 1'b0;
      check_eq("start_out0", 32'(outstanding), 32'd0);
      gfx_last = 1'b1; expect_swap(cyc + 3); tick(1); gfx_last = 1'b0;
      tick(5);
      check_eq("start_disp", 32'(disp_enable), 32'd1);
      check_eq("start_frame", 32'(frame_cnt), 32'd1);

      // Drain gating, then swap two cycles after the vsync fall.
      wr_issue = 1'b1; tick(2); wr_issue = 1'b0;
      gfx_last = 1'b1; tick(1); gfx_last = 1'b0;
      check_eq("drain_out2", 32'(outstanding), 32'd2);
      tick(4);
      wr_done = 1'b1; tick(1); wr_done = 1'b0;
      tick(5);
      wr_done = 1'b1; tick(1); wr_done = 1'b0;
      tick(4);
      check_eq("drain_out0", 32'(outstanding), 32'd0);
      vsync_fall_now();
      tick(5);
      check_eq("vs_frame", 32'(frame_cnt), 32'd2);
      check_eq("vs_drop0", 32'(drop_cnt), 32'd0);

      // Three vsync falls while drawing: all dropped.
      repeat (3) begin
         vsync_drop();
         tick(3);
      end
      check_eq("drop3", 32'(drop_cnt), 32'd3);
      check_eq("drop_frame", 32'(frame_cnt), 32'd2);

      // Edge during DRAIN is counted as a drop and not remembered.
      wr_issue = 1'b1; tick(1); wr_issue = 1'b0;
      gfx_last = 1'b1; tick(1); gfx_last = 1'b0;
      tick(2);
      vsync_drop();
      tick(3);
      check_eq("drain_edge_drop", 32'(drop_cnt), 32'd4);
      wr_done = 1'b1; tick(1); wr_done = 1'b0;
      tick(8);
      check_eq("drain_edge_frame", 32'(frame_cnt), 32'd2);
      vsync_fall_now();
      tick(5);
      check_eq("drain_edge_swap", 32'(frame_cnt), 32'd3);

      // Edge coinciding with READY entry: no swap until a later edge.
      gfx_last = 1'b1; vsync = 1'b0; tick(1); gfx_last = 1'b0; vsync = 1'b1;
      tick(6);
      check_eq("same_cyc_drop", 32'(drop_cnt), 32'd5);
      check_eq("same_cyc_frame", 32'(frame_cnt), 32'd3);
      vsync_fall_now();
      tick(5);
      check_eq("same_cyc_swap", 32'(frame_cnt), 32'd4);

      // Write counter corners.
      wr_issue = 1'b1; wr_done = 1'b1; tick(1); wr_issue = 1'b0; wr_done = 1'b0;
      check_eq("both_at0_out", 32'(outstanding), 32'd0);
      check_eq("both_at0_err", 32'(err), 32'd0);
      wr_issue = 1'b1; tick(1);
      wr_done = 1'b1; tick(1); wr_issue = 1'b0; wr_done = 1'b0;
      check_eq("both_at1_out", 32'(outstanding), 32'd1);
      wr_issue = 1'b1; tick(16); wr_issue = 1'b0;
      check_eq("sat_out", 32'(outstanding), 32'd15);
      check_eq("sat_err", 32'(err), 32'd1);
      tick(2);
      check_eq("err_sticky", 32'(err), 32'd1);

      // Reset mid-DRAIN with 5 writes in flight.
      reset = 1'b1; tick(1); reset = 1'b0;
      wr_issue = 1'b1; tick(5); wr_issue = 1'b0;
      gfx_last = 1'b1; tick(1); gfx_last = 1'b0;
      tick(2);
      check_eq("pre_rst_out5", 32'(outstanding), 32'd5);
      reset = 1'b1; tick(1);
      check_reset_vals("mid_rst");
      reset = 1'b0; tick(1);
      wr_done = 1'b1; tick(1); wr_done = 1'b0;
      check_eq("under_out", 32'(outstanding), 32'd0);
      check_eq("under_err", 32'(err), 32'd1);
      gfx_last = 1'b1; expect_swap(cyc + 3); tick(1); gfx_last = 1'b0;
      tick(6);
      check_eq("fresh_disp", 32'(disp_enable), 32'd1);
      check_eq("fresh_frame", 32'(frame_cnt), 32'd1);

      check_eq("pending_swaps", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
